mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO.
//
// Multiplies run for MUL_CYCLES cycles. Divides use a restoring divider
// that produces one quotient bit per cycle and runs for 32 cycles. MTHI and
// MTLO write HI or LO directly in a single cycle. HI/LO change only on a
// commit edge, so a result is never seen half-built.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start_i         request strobe, sampled at the clk edge
//   cancel_i        flush; blocks a start_i in the same cycle
//   op_i[2:0]       0/7 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//   opr1_i[31:0]    multiplicand / dividend / MTHI-MTLO data
//   opr2_i[31:0]    multiplier / divisor
//   hi_o, lo_o      architectural HI and LO registers
//   busy_o          a multiply or divide is in flight
//   div_active_o    a divide is in flight
//   done_o          one-cycle pulse in the cycle after HI/LO take a result
//
// state | meaning
// IDLE  | ready to accept; MTHI/MTLO and divide-by-zero finish here
// MUL   | multiply in flight, cnt_q counts down to the commit edge
// DIV   | restoring divide, one quotient bit per cycle, cnt_q from 31 to 0
module mdu_ctrl #(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        cancel_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] opr1_i,
   input  logic [31:0] opr2_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        div_active_o,
   output logic        done_o
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [63:0] mul_a_q, mul_b_q;
   logic [31:0] rem_q, quo_q, dvsr_q;
   logic        neg_quo_q, neg_rem_q;
   logic [31:0] hi_q, lo_q;
   logic        done_q;

   logic        accept, is_mul, is_div, is_signed, div_zero;
   logic [31:0] a_abs, b_abs;
   logic [63:0] product;
   logic [31:0] rem_sh, rem_nxt, quo_nxt, quo_fin, rem_fin;
   logic        rem_ge;

   assign accept    = (state_q == IDLE) && start_i && !cancel_i;
   assign is_mul    = (op_i == 3'd1) || (op_i == 3'd2);
   assign is_div    = (op_i == 3'd3) || (op_i == 3'd4);
   assign is_signed = (op_i == 3'd1) || (op_i == 3'd3);
   assign div_zero  = (opr2_i == 32'd0);

   assign a_abs = (is_signed && opr1_i[31]) ? -opr1_i : opr1_i;
   assign b_abs = (is_signed && opr2_i[31]) ? -opr2_i : opr2_i;

   assign product = mul_a_q * mul_b_q;

   // The bit shifted out of rem_q is the 33rd bit of the trial remainder.
   // When it is set, the trial is at least the divisor, and the 32-bit
   // subtraction still gives the right answer because that answer is
   // smaller than the divisor.
   assign rem_sh  = {rem_q[30:0], quo_q[31]};
   assign rem_ge  = rem_q[31] || (rem_sh >= dvsr_q);
   assign rem_nxt = rem_ge ? (rem_sh - dvsr_q) : rem_sh;
   assign quo_nxt = {quo_q[30:0], rem_ge};
   assign quo_fin = neg_quo_q ? -quo_nxt : quo_nxt;
   assign rem_fin = neg_rem_q ? -rem_nxt : rem_nxt;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && is_mul)
               state_d = MUL;
            else if (accept && is_div && !div_zero)
               state_d = DIV;
         end
         MUL:     if (cnt_q == 5'd0) state_d = IDLE;
         DIV:     if (cnt_q == 5'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 5'd0;
         mul_a_q   <= 64'd0;
         mul_b_q   <= 64'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvsr_q    <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (op_i == 3'd5)
                     hi_q <= opr1_i;
                  else if (op_i == 3'd6)
                     lo_q <= opr1_i;
                  else if (is_mul) begin
                     mul_a_q <= is_signed ? {{32{opr1_i[31]}}, opr1_i} : {32'd0, opr1_i};
                     mul_b_q <= is_signed ? {{32{opr2_i[31]}}, opr2_i} : {32'd0, opr2_i};
                     cnt_q   <= 5'(MUL_CYCLES - 1);
                  end else if (is_div) begin
                     if (div_zero)
                        done_q <= 1'b1;
                     else begin
                        quo_q     <= a_abs;
                        dvsr_q    <= b_abs;
                        rem_q     <= 32'd0;
                        neg_quo_q <= is_signed && (opr1_i[31] ^ opr2_i[31]);
                        neg_rem_q <= is_signed && opr1_i[31];
                        cnt_q     <= 5'd31;
                     end
                  end
               end
            end
            MUL: begin
               if (cnt_q == 5'd0) begin
                  hi_q   <= product[63:32];
                  lo_q   <= product[31:0];
                  done_q <= 1'b1;
               end else
                  cnt_q <= cnt_q - 5'd1;
            end
            DIV: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               if (cnt_q == 5'd0) begin
                  hi_q   <= rem_fin;
                  lo_q   <= quo_fin;
                  done_q <= 1'b1;
               end else
                  cnt_q <= cnt_q - 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign hi_o         = hi_q;
   assign lo_o         = lo_q;
   assign busy_o       = (state_q != IDLE);
   assign div_active_o = (state_q == DIV);
   assign done_o       = done_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl. Each expected commit is queued as a
// {hi, lo} value, and a monitor compares it against the outputs on
// every done_o pulse.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        cancel_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] opr1_i = 32'd0;
   logic [31:0] opr2_i = 32'd0;
   logic [31:0] hi_o, lo_o;
   logic        busy_o, div_active_o, done_o;

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_q[$];

   mdu_ctrl #(.MUL_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .cancel_i(cancel_i),
      .op_i(op_i), .opr1_i(opr1_i), .opr2_i(opr2_i),
      .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o),
      .div_active_o(div_active_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_unexpected: got done_o=1 hi=%h lo=%h, expected no pulse", hi_o, lo_o);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("result_hilo", {hi_o, lo_o}, e);
         end
      end
   end

   // Drives one request and holds it for a single edge. It then counts
   // busy and div-active cycles until IDLE is reached, and flags any change
   // to HI/LO while the operation is busy.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cancel,
                         input int exp_busy, input int exp_div);
      int nb, nd;
      logic [63:0] held;
      logic changed;
      @(posedge clk); #1;
      start_i = 1'b1; cancel_i = cancel; op_i = op; opr1_i = a; opr2_i = b;
      @(posedge clk); #1;
      start_i = 1'b0; cancel_i = 1'b0; op_i = 3'd0;
      held = {hi_o, lo_o};
      changed = 1'b0;
      nb = 0; nd = 0;
      @(negedge clk);
      while (busy_o && nb < 200) begin
         nb++;
         if (div_active_o) nd++;
         if ({hi_o, lo_o} !== held) changed = 1'b1;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
      check({name, "_div_cycles"}, 64'(nd), 64'(exp_div));
      if (exp_busy > 0) check({name, "_hilo_stable"}, 64'(changed), 64'd0);
   endtask

   initial begin
      int n;
      logic hit;
      // reset state
      @(negedge clk);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      check("rst_flags", {61'd0, busy_o, div_active_o, done_o}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      run_op("mthi", 3'd5, 32'd5, 32'd0, 1'b0, 0, 0);
      run_op("mtlo", 3'd6, 32'd6, 32'd0, 1'b0, 0, 0);
      check("mth_mtl", {hi_o, lo_o}, {32'd5, 32'd6});

      // divide by zero: HI/LO unchanged, done_o on the next cycle
      exp_q.push_back({32'd5, 32'd6});
      run_op("divu0", 3'd4, 32'd100, 32'd0, 1'b0, 0, 0);

      exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
      run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, 0);

      exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
      run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 32, 32);

      exp_q.push_back({32'h00000000, 32'h80000000});
      run_op("div_wrap", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32, 32);

      exp_q.push_back({32'h00000003, 32'h24924924});
      run_op("divu_big", 3'd4, 32'hFFFFFFFF, 32'd7, 1'b0, 32, 32);

      exp_q.push_back({32'h00000001, 32'hFFFFFFFD});
      run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 32, 32);

      exp_q.push_back({32'hFFFFFFFF, 32'h00000002});
      run_op("mult_neg", 3'd1, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 3, 0);

      // MULT -1 x -1 while an MTHI request is held for the whole busy period
      exp_q.push_back({32'd0, 32'd1});
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd1; opr1_i = 32'hFFFFFFFF; opr2_i = 32'hFFFFFFFF;
      @(posedge clk); #1;
      op_i = 3'd5; opr1_i = 32'h1234;
      n = 0;
      @(negedge clk);
      while (busy_o && n < 200) begin n++; @(negedge clk); end
      start_i = 1'b0; op_i = 3'd0;
      check("mult_reissue_busy", 64'(n), 64'd3);
      @(posedge clk); #1;
      check("mult_reissue_hilo", {hi_o, lo_o}, {32'd0, 32'd1});

      // a request made in the first IDLE cycle is accepted at once
      exp_q.push_back({32'd0, 32'd12});
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd2; opr1_i = 32'd3; opr2_i = 32'd4;
      @(posedge clk); #1;
      start_i = 1'b0;
      n = 0;
      while (busy_o && n < 200) begin n++; @(posedge clk); #1; end
      start_i = 1'b1; op_i = 3'd6; opr1_i = 32'hABCD;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'd0;
      check("b2b_mtlo", 64'(lo_o), 64'h0000ABCD);

      // cancel blocks the request
      run_op("cancel", 3'd3, 32'd10, 32'd3, 1'b1, 0, 0);
      repeat (3) @(posedge clk);
      #1 check("cancel_hilo", {hi_o, lo_o}, {32'd0, 32'h0000ABCD});

      // reset during a divide
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'd3; opr1_i = 32'd10; opr2_i = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'd0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_outs", {hi_o, lo_o}, 64'd0);
      check("midrst_flags", {61'd0, busy_o, div_active_o, done_o}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      hit = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy_o || done_o) hit = 1'b1;
      end
      check("postrst_quiet", 64'(hit), 64'd0);
      check("postrst_hilo", {hi_o, lo_o}, 64'd0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
